// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit line memory port between I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_arbiter (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [27:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic         i_ready,
  output logic [127:0] i_rdata,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [27:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic         d_ready,
  output logic [127:0] d_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t       state_q, state_d;
  logic         rd_q, rd_d, wr_q, wr_d;
  logic [27:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic         last_q, last_d;
  logic         i_pend, d_pend, pick_d;
  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;
  // last_q = 1 means the D-cache was served most recently
`ifdef MEM_ARB_RR_EN
  assign pick_d = d_pend & (~i_pend | ~last_q);
`else
  assign pick_d = d_pend;
`endif
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (i_pend | d_pend) begin
        state_d = pick_d ? GNT_D : GNT_I;
        addr_d  = pick_d ? d_addr : i_addr;
        wdata_d = pick_d ? d_wdata : i_wdata;
        wr_d    = pick_d ? d_write : i_write;
        rd_d    = pick_d ? d_read & ~d_write : i_read & ~i_write;
      end
      default: if (mem_ready) begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        last_d  = state_q == GNT_D;
      end
    endcase
  end
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = mem_ready & (state_q == GNT_I);
  assign d_ready   = mem_ready & (state_q == GNT_D);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven checks of mem_arbiter plus reset/stray-ready sequences.
module tb_mem_arbiter;
  logic         clk = 1'b0, proc_reset_n = 1'b0;
  logic         i_read = 0, i_write = 0, d_read = 0, d_write = 0;
  logic [27:0]  i_addr = '0, d_addr = '0;
  logic [127:0] i_wdata = '0, d_wdata = '0;
  logic         i_ready, d_ready, mem_read, mem_write, mem_ready = 0;
  logic [127:0] i_rdata, d_rdata, mem_wdata, mem_rdata = '0;
  logic [27:0]  mem_addr;
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ir, iw, dr, dw;
    logic [27:0]  ia, da;
    logic [127:0] iwd, dwd, rdata;
    logic         gd, erd, ewr;
    logic [27:0]  ea;
    logic [127:0] ewd;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
  endtask

  task automatic pulse_ready(input logic [127:0] data, input logic ei, input logic ed, input string tag);
    mem_rdata = data;
    mem_ready = 1;
    #1;
    chk({tag, " i_ready"}, 128'(i_ready), 128'(ei));
    chk({tag, " d_ready"}, 128'(d_ready), 128'(ed));
    chk({tag, " rdata"}, ei ? i_rdata : d_rdata, data);
    tick();
    mem_ready = 0;
    chk({tag, " strobes off"}, 128'({mem_read, mem_write}), 128'(0));
  endtask

  logic exp_d;

  initial begin
    tbl[0] = '{1,0,0,0, 28'h0000123, 28'h0, 128'h0, 128'h0, {16{8'hA5}}, 0,1,0, 28'h0000123, 128'h0};
    tbl[1] = '{0,0,0,1, 28'h0, 28'h00000A4, 128'h0, 128'h1, 128'h0, 1,0,1, 28'h00000A4, 128'h1};
    tbl[2] = '{0,0,1,0, 28'h0, 28'h00000A4, 128'h0, 128'h0, 128'h5A, 1,1,0, 28'h00000A4, 128'h0};
`ifdef MEM_ARB_RR_EN
    tbl[3] = '{1,0,1,0, 28'h0000111, 28'h0000222, 128'h11, 128'h22, 128'h33, 0,1,0, 28'h0000111, 128'h11};
`else
    tbl[3] = '{1,0,1,0, 28'h0000111, 28'h0000222, 128'h11, 128'h22, 128'h33, 1,1,0, 28'h0000222, 128'h22};
`endif
    tbl[4] = '{1,1,0,0, 28'h0000333, 28'h0, 128'hBEEF, 128'h0, 128'h0, 0,0,1, 28'h0000333, 128'hBEEF};
    tbl[5] = '{0,0,1,1, 28'h0, 28'h0000444, 128'h0, 128'hCAFE, 128'h0, 1,0,1, 28'h0000444, 128'hCAFE};

    // reset state, with a stray mem_ready while held
    #2;
    mem_ready = 1;
    #1;
    chk("rst strobes", 128'({mem_read, mem_write}), 128'(0));
    chk("rst addr", 128'(mem_addr), 128'(0));
    chk("rst wdata", mem_wdata, 128'(0));
    chk("rst readies", 128'({i_ready, d_ready}), 128'(0));
    mem_ready = 0;
    tick();
    tick();
    proc_reset_n = 1;

    for (int k = 0; k < 6; k++) begin
      i_read = tbl[k].ir; i_write = tbl[k].iw; d_read = tbl[k].dr; d_write = tbl[k].dw;
      i_addr = tbl[k].ia; d_addr = tbl[k].da; i_wdata = tbl[k].iwd; d_wdata = tbl[k].dwd;
      tick();
      drop_all();
      chk($sformatf("v%0d mem_read", k), 128'(mem_read), 128'(tbl[k].erd));
      chk($sformatf("v%0d mem_write", k), 128'(mem_write), 128'(tbl[k].ewr));
      chk($sformatf("v%0d mem_addr", k), 128'(mem_addr), 128'(tbl[k].ea));
      chk($sformatf("v%0d mem_wdata", k), mem_wdata, tbl[k].ewd);
      chk($sformatf("v%0d no early ready", k), 128'({i_ready, d_ready}), 128'(0));
      tick();
      chk($sformatf("v%0d hold", k), 128'({mem_read, mem_write, mem_addr}), 128'({tbl[k].erd, tbl[k].ewr, tbl[k].ea}));
      pulse_ready(tbl[k].rdata, ~tbl[k].gd, tbl[k].gd, $sformatf("v%0d", k));
    end

    // continuous tie after reset: D first in both builds
    proc_reset_n = 0;
    #1;
    proc_reset_n = 1;
    i_read = 1; d_read = 1; i_addr = 28'h0000A11; d_addr = 28'h0000D22;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = 1;
`endif
      tick();
      chk($sformatf("tie%0d addr", k), 128'(mem_addr), exp_d ? 128'(28'h0000D22) : 128'(28'h0000A11));
      chk($sformatf("tie%0d mem_read", k), 128'(mem_read), 128'(1));
      pulse_ready(128'(k), ~exp_d, exp_d, $sformatf("tie%0d", k));
    end
    drop_all();
    tick();

    // request withdrawn mid-grant
    d_read = 1; d_addr = 28'h0000777;
    tick();
    tick();
    d_read = 0;
    chk("wd hold1", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h0000777}));
    tick();
    chk("wd hold2", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h0000777}));
    pulse_ready(128'h77, 0, 1, "wd");
    tick();
    chk("wd idle", 128'({mem_read, mem_write}), 128'(0));

    // asynchronous reset mid-grant
    i_read = 1; i_addr = 28'h0000999; i_wdata = 128'h99;
    tick();
    chk("rg granted", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h0000999}));
    #2;
    proc_reset_n = 0;
    #1;
    chk("rg strobes", 128'({mem_read, mem_write}), 128'(0));
    chk("rg addr", 128'(mem_addr), 128'(0));
    chk("rg wdata", mem_wdata, 128'(0));
    mem_ready = 1;
    #1;
    chk("rg ready held", 128'({i_ready, d_ready}), 128'(0));
    mem_ready = 0;
    @(negedge clk);
    proc_reset_n = 1;
    tick();
    chk("rg regrant", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h0000999}));
    i_read = 0;
    pulse_ready(128'h123, 1, 0, "rg");

    // stray mem_ready in IDLE
    mem_ready = 1;
    #1;
    chk("stray readies", 128'({i_ready, d_ready}), 128'(0));
    tick();
    mem_ready = 0;
    chk("stray strobes", 128'({mem_read, mem_write}), 128'(0));
    d_read = 1; d_addr = 28'h0000555;
    tick();
    d_read = 0;
    chk("stray then grant", 128'({mem_read, mem_addr}), 128'({1'b1, 28'h0000555}));
    pulse_ready(128'h55, 0, 1, "post-stray");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
